if_id_pipeline_reg: RTL and testbench

IF/ID pipeline register between the fetch stage and decode. Aligns the synchronous program-memory read data (one cycle behind the fetch address) with its return address (PC+1) and presents a registered instruction/valid pair to decode. Absorbs the memory's in-flight word on stall through a one-entry skid buffer and squashes wrong-path words on flush.

---
 rtl/if_id_pipeline_reg_pkg.sv | 15 +
 rtl/if_id_pipeline_reg_if.sv | 37 +++
 rtl/if_id_skid_buffer.sv | 40 ++++
 rtl/if_id_pipeline_reg.sv | 102 ++++++++++
 tb/tb_if_id_pipeline_reg.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/if_id_pipeline_reg_pkg.sv
// Shared fetch/decode datapath definitions: IF/ID state encoding, bubble word and program-address width.
package if_id_pipeline_reg_pkg;

  localparam int unsigned PROG_ADDR_WIDTH = 14;
  localparam int unsigned PROG_WORD_WIDTH = 16;
  localparam logic [PROG_WORD_WIDTH-1:0] NOP_INSTR_WORD = 16'h0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD,
    SQUASH
  } if_id_state_e;

endpackage

// File: rtl/if_id_pipeline_reg_if.sv
// Fetch/hazard-to-decode bundle around the IF/ID register; master is the fetch/hazard side.
interface if_id_pipeline_reg_if
  import if_id_pipeline_reg_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = PROG_WORD_WIDTH,
  parameter int unsigned ADDR_WIDTH  = PROG_ADDR_WIDTH
);

  logic                   stall;
  logic                   flush;
  logic [INSTR_WIDTH-1:0] prog_mem_read_data;
  logic [ADDR_WIDTH-1:0]  ret_addr_in;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic [ADDR_WIDTH-1:0]  ret_addr_out;
  logic                   instr_valid;

  modport master (
    output stall,
    output flush,
    output prog_mem_read_data,
    output ret_addr_in,
    input  instr_out,
    input  ret_addr_out,
    input  instr_valid
  );

  modport slave (
    input  stall,
    input  flush,
    input  prog_mem_read_data,
    input  ret_addr_in,
    output instr_out,
    output ret_addr_out,
    output instr_valid
  );

endinterface

// File: rtl/if_id_skid_buffer.sv
// One-entry {data, addr, full} skid register; clear wins over read, read wins over capture.
module if_id_skid_buffer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 14
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  i_capture,
  input  logic                  i_read,
  input  logic                  i_clear,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_full
);

  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_full;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_data <= '0;
      r_addr <= '0;
      r_full <= 1'b0;
    end else if (i_clear || i_read) begin
      r_full <= 1'b0;
    end else if (i_capture) begin
      r_data <= i_data;
      r_addr <= i_addr;
      r_full <= 1'b1;
    end
  end

  assign o_data = r_data;
  assign o_addr = r_addr;
  assign o_full = r_full;

endmodule

// File: rtl/if_id_pipeline_reg.sv
// IF/ID register: aligns synchronous program-memory data with its PC+1, skids the in-flight
// word across stalls and emits bubbles after reset and for two edges from a flush.
module if_id_pipeline_reg
  import if_id_pipeline_reg_pkg::*;
#(
  parameter int unsigned            INSTR_WIDTH = PROG_WORD_WIDTH,
  parameter int unsigned            ADDR_WIDTH  = PROG_ADDR_WIDTH,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(NOP_INSTR_WORD)
) (
  input logic                 clock,
  input logic                 nreset,
  if_id_pipeline_reg_if.slave bus
);

  if_id_state_e           r_state;
  logic [ADDR_WIDTH-1:0]  r_ret_addr_d1;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0]  r_ret_addr;
  logic                   r_valid;

  logic                   w_skid_capture;
  logic                   w_skid_read;
  logic                   w_skid_clear;
  logic                   w_skid_full;
  logic [INSTR_WIDTH-1:0] w_skid_instr;
  logic [ADDR_WIDTH-1:0]  w_skid_addr;

  // The first stalled edge in RUN is the only one where the memory word would otherwise be lost.
  always_comb begin
    w_skid_clear   = bus.flush;
    w_skid_capture = !bus.flush && bus.stall && (r_state == RUN);
    w_skid_read    = !bus.flush && !bus.stall && (r_state == HOLD);
  end

  if_id_skid_buffer #(
    .DATA_WIDTH(INSTR_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_skid (
    .clock    (clock),
    .nreset   (nreset),
    .i_capture(w_skid_capture),
    .i_read   (w_skid_read),
    .i_clear  (w_skid_clear),
    .i_data   (bus.prog_mem_read_data),
    .i_addr   (r_ret_addr_d1),
    .o_data   (w_skid_instr),
    .o_addr   (w_skid_addr),
    .o_full   (w_skid_full)
  );

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_ret_addr_d1 <= '0;
    end else if (!bus.stall) begin
      r_ret_addr_d1 <= bus.ret_addr_in;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state    <= BOOT;
      r_instr    <= NOP_INSTR;
      r_ret_addr <= '0;
      r_valid    <= 1'b0;
    end else if (bus.flush) begin
      r_state    <= SQUASH;
      r_instr    <= NOP_INSTR;
      r_ret_addr <= '0;
      r_valid    <= 1'b0;
    end else if (bus.stall) begin
      if (r_state == RUN) begin
        r_state <= HOLD;
      end
    end else begin
      case (r_state)
        RUN: begin
          r_instr    <= bus.prog_mem_read_data;
          r_ret_addr <= r_ret_addr_d1;
          r_valid    <= 1'b1;
        end
        // Memory word in the release cycle is the re-read of the held PC, so the skid is used instead.
        HOLD: begin
          r_state    <= RUN;
          r_instr    <= w_skid_instr;
          r_ret_addr <= w_skid_addr;
          r_valid    <= w_skid_full;
        end
        default: begin
          r_state    <= RUN;
          r_instr    <= NOP_INSTR;
          r_ret_addr <= '0;
          r_valid    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.instr_out    = r_instr;
  assign bus.ret_addr_out = r_ret_addr;
  assign bus.instr_valid  = r_valid;

endmodule

// File: tb/tb_if_id_pipeline_reg.sv
// Bench for if_id_pipeline_reg: a fetch/memory environment plus a decode-stream queue model.
module tb_if_id_pipeline_reg;
  import if_id_pipeline_reg_pkg::*;

  localparam int unsigned IW = 16;
  localparam int unsigned AW = 14;
  localparam logic [IW-1:0] NOP = 16'h0000;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  if_id_pipeline_reg_if #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

  if_id_pipeline_reg #(
    .INSTR_WIDTH(IW),
    .ADDR_WIDTH (AW),
    .NOP_INSTR  (NOP)
  ) dut (
    .clock (clk),
    .nreset(nreset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] ret;
  } word_t;

  logic [IW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] pc;
  logic [IW-1:0] rdata;
  word_t         q[$];
  logic [IW-1:0] exp_instr;
  logic [AW-1:0] exp_ret;
  logic          exp_valid;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " instr"}, 32'(bus.instr_out), 32'(exp_instr));
    check({tag, " ret"}, 32'(bus.ret_addr_out), 32'(exp_ret));
    check({tag, " valid"}, 32'(bus.instr_valid), 32'(exp_valid));
  endtask

  task automatic set_bubble();
    exp_instr = NOP;
    exp_ret   = '0;
    exp_valid = 1'b0;
  endtask

  // One clock: drive, update decode model and fetch environment on the edge, check at negedge.
  task automatic step(input logic s, input logic f, input logic [AW-1:0] tgt, input string tag);
    word_t w;
    bus.stall              = s;
    bus.flush              = f;
    bus.ret_addr_in        = pc + 1'b1;
    bus.prog_mem_read_data = rdata;
    @(posedge clk);
    if (f) begin
      q.delete();
      set_bubble();
    end else if (!s) begin
      if (q.size() > 0) begin
        w = q.pop_front();
        exp_instr = w.instr;
        exp_ret   = w.ret;
        exp_valid = 1'b1;
      end else begin
        set_bubble();
      end
      q.push_back({mem[pc], AW'(pc + 1'b1)});
    end
    rdata = mem[pc];
    pc    = f ? tgt : (s ? pc : AW'(pc + 1'b1));
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic pulse_reset(input string tag);
    nreset    = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    #1;
    q.delete();
    set_bubble();
    pc    = '0;
    rdata = IW'($urandom);
    check_outputs({tag, " async"});
    @(posedge clk);
    @(negedge clk);
    check_outputs({tag, " held"});
    nreset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = IW'($urandom);
    mem[0]       = 16'h1111;
    mem[1]       = 16'h2222;
    mem[14'h100] = 16'hBEEF;

    bus.stall              = 1'b0;
    bus.flush              = 1'b0;
    bus.ret_addr_in        = '0;
    bus.prog_mem_read_data = '0;
    pc                     = '0;
    rdata                  = '0;
    pulse_reset("reset");

    step(1'b0, 1'b0, '0, "boot bubble");
    step(1'b0, 1'b0, '0, "addr0");
    check("addr0 const instr", 32'(bus.instr_out), 32'h1111);
    check("addr0 const ret", 32'(bus.ret_addr_out), 32'd1);
    step(1'b0, 1'b0, '0, "addr1");
    check("addr1 const instr", 32'(bus.instr_out), 32'h2222);
    check("addr1 const ret", 32'(bus.ret_addr_out), 32'd2);

    step(1'b1, 1'b0, '0, "stall1 hold");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, "stall1 drain");

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, "stall5 hold");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, "stall5 drain");

    step(1'b0, 1'b1, 14'h100, "flush edge");
    step(1'b0, 1'b0, '0, "flush bubble2");
    step(1'b0, 1'b0, '0, "flush target");
    check("target const instr", 32'(bus.instr_out), 32'hBEEF);
    check("target const ret", 32'(bus.ret_addr_out), 32'h101);
    step(1'b0, 1'b0, '0, "after target");

    step(1'b1, 1'b0, '0, "hold enter");
    step(1'b1, 1'b0, '0, "hold stay");
    step(1'b1, 1'b1, 14'h200, "flush+stall");
    step(1'b1, 1'b0, '0, "squash stalled");
    step(1'b0, 1'b0, '0, "squash release");
    step(1'b0, 1'b0, '0, "squash target");
    check("squash target valid", 32'(bus.instr_valid), 32'd1);

    step(1'b1, 1'b0, '0, "pre-reset hold");
    step(1'b1, 1'b0, '0, "pre-reset hold2");
    pulse_reset("reset mid-hold");
    step(1'b0, 1'b0, '0, "restart bubble");
    step(1'b0, 1'b0, '0, "restart addr0");
    check("restart const instr", 32'(bus.instr_out), 32'h1111);
    check("restart const ret", 32'(bus.ret_addr_out), 32'd1);

    for (int i = 0; i < 2000; i++) begin
      logic s;
      logic f;
      s = ($urandom_range(99) < 25);
      f = ($urandom_range(99) < 6);
      step(s, f, AW'($urandom), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
